alu_src_select_reg: RTL and testbench
=====================================

# alu_src_select_reg

Parametrised, registered successor to the ALU A-operand selector. It picks one of `NUM_SRC` operand sources per transaction and registers the result behind a valid/ready handshake with a 2-entry skid buffer, so operand fetch decouples from the ALU stage. Each beat also carries its select tag and an illegal-select flag. The block sits between the register/PC/MDR datapath and the ALU A input of the multicycle core.

## Interface
- `WIDTH`, 32: operand width in bits.
- `NUM_SRC`, 3: number of selectable sources, 2..16.
- `SEL_W`, `$clog2(NUM_SRC)` (minimum 1): select width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: upstream beat present.
- `in_ready`  out  1: block can accept a beat this cycle.
- `sel`  in  SEL_W: source index, sampled with the beat.
- `src_data`  in  NUM_SRC*WIDTH: flattened sources; source i is at bits [i*WIDTH +: WIDTH].
- `out_valid`  out  1: output beat present.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  WIDTH: selected operand.
- `out_sel`  out  SEL_W: select tag of the current beat.
- `out_err`  out  1: the beat's `sel` was >= NUM_SRC.

## Operation
- Accept occurs when `in_valid && in_ready`. Emit occurs when `out_valid && out_ready`.
- On accept, the beat captures `{src_data[sel], sel, 0}`. If `sel >= NUM_SRC`, it captures `{0, sel, 1}`. Data is sampled only in the accept cycle; later changes to `src_data` do not affect a stored beat.
- Storage: main register (drives outputs) plus one skid register.
- States:
  - EMPTY: nothing stored.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Transitions:
  - EMPTY, accept -> ONE.
  - ONE, accept only -> TWO; the beat goes to the skid register.
  - ONE, emit only -> EMPTY.
  - ONE, accept and emit -> ONE; main register is loaded with the new beat.
  - TWO, emit -> ONE; the skid register moves to the main register.
  - TWO, no emit -> TWO.
- `in_ready` is low only in TWO. It is a registered flop, not combinational from `out_ready`, so there is no in-to-out ready path.
- `out_valid` = state != EMPTY. The `out_data`, `out_sel` and `out_err` outputs come straight from main-register flops.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- When `out_valid=0`, `out_data`, `out_sel` and `out_err` hold their last values (don't-care to consumers).

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on the outputs after edge k and can be emitted at edge k+1.
- Throughput is 1 beat/cycle while `out_ready` stays high.
- With `out_ready` low: two beats are accepted, then `in_ready` drops in the cycle after the second accept.
- `in_ready` rises the cycle after the first emit from TWO.
- Reset values: state EMPTY, `in_ready=1`, `out_valid=0`, `out_data=0`, `out_sel=0`, `out_err=0`, skid register cleared.
- Reset asserted mid-operation discards both stored beats at that edge. An accept or emit attempted in a reset cycle has no effect.
- Simultaneous accept and emit in ONE is legal and keeps throughput.
- In TWO, accept cannot occur because `in_ready=0`.

## Structure
- Shared package `alu_src_pkg`:
  - default `WIDTH`;
  - source index constants `SRC_PC=0`, `SRC_A=1`, `SRC_MDR=2`;
  - state enum `{S_EMPTY, S_ONE, S_TWO}`.
- Sub-module `skid_reg`: generic 2-entry valid/ready register, parametrised by payload width. The top level builds the payload `{err, sel, data}` and instantiates `skid_reg` once.
- Selection logic is a plain indexed part-select with a range check.

## Test plan
- Reset, then `sel=1` with source A=0x0000_00A5 and `out_ready=1` -> one cycle later `out_valid=1`, `out_data=0x0000_00A5`, `out_sel=1`, `out_err=0`.
- Back-to-back beats with `sel`=0,1,2 and sources PC=0x100, A=0x200, MDR=0x300, `out_ready=1` -> outputs 0x100, 0x200, 0x300 on consecutive cycles; `in_ready` stays 1.
- `out_ready=0`, push two beats (0x11, 0x22) -> `in_ready=0` after the second accept. Raise `out_ready` -> 0x11 then 0x22 are emitted in order; `in_ready` returns to 1 the cycle after the first emit.
- `sel=3` with NUM_SRC=3 -> `out_data=0`, `out_sel=3`, `out_err=1`. The next beat with `sel=0` has `out_err=0`.
- Hold a beat captured with A=0x5 while `src_data` changes to 0xFF before emit -> the emitted value is 0x5.
- State TWO, assert `reset` for one cycle -> next cycle `out_valid=0`, `in_ready=1`, outputs zero; no stale beat appears afterward.

Source files
------------

// File: rtl/alu_src_pkg.sv
// rtl/alu_src_pkg.sv - shared constants and types for the ALU A-operand selector
package alu_src_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam int SRC_PC  = 0;
  localparam int SRC_A   = 1;
  localparam int SRC_MDR = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  // Select width for a given source count, never below one bit
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_src_select_reg_if.sv
// rtl/alu_src_select_reg_if.sv - upstream/downstream handshake bundle for the selector
interface alu_src_select_reg_if
  import alu_src_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = sel_width(NUM_SRC)
);

  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_err;

  // Driver side: feeds beats in and consumes them out
  modport master (
    output in_valid, sel, src_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_err
  );

  // Block side
  modport slave (
    input  in_valid, sel, src_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_err
  );

endinterface

// File: rtl/alu_src_select_reg_skid.sv
// rtl/alu_src_select_reg_skid.sv - generic 2-entry valid/ready skid register (skid_reg)
module skid_reg
  import alu_src_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;
  logic         emit;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  // Next-state and storage moves; ready/valid are precomputed from the next state
  // so both leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && emit) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = S_TWO;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  // State and storage registers; reset drops any stored beats
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/alu_src_select_reg.sv
// rtl/alu_src_select_reg.sv - registered ALU A-operand selector with skid buffering
module alu_src_select_reg
  import alu_src_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = sel_width(NUM_SRC)
) (
  input logic                  clk,
  input logic                  reset,
  alu_src_select_reg_if.slave  bus
);

  localparam int PW = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;

  // Pick the addressed source; an out-of-range select yields zero data and the error flag
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    if (int'(bus.sel) < NUM_SRC) begin
      sel_data = bus.src_data[int'(bus.sel)*WIDTH +: WIDTH];
      sel_err  = 1'b0;
    end
  end

  assign in_payload = {sel_err, bus.sel, sel_data};

  skid_reg #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign {bus.out_err, bus.out_sel, bus.out_data} = out_payload;

endmodule

// File: tb/tb_alu_src_select_reg.sv
// tb/tb_alu_src_select_reg.sv - self-checking bench for alu_src_select_reg
module tb_alu_src_select_reg;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_src_select_reg_if #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2)) bus ();

  alu_src_select_reg #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] mdr;
    logic        ordy;
    logic        e_valid;
    logic        e_rdy;
    logic        chk_d;
    logic [31:0] e_data;
    logic [1:0]  e_sel;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        err;
  } beat_t;

  int n_vec = 0;
  int n_err = 0;

  vec_t  tbl[$];
  beat_t mq[$];
  logic  m_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [1:0] sel,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] mdr,
                       input logic ordy);
    reset         = rst;
    bus.in_valid  = iv;
    bus.sel       = sel;
    bus.src_data  = {mdr, a, pc};
    bus.out_ready = ordy;
  endtask

  function automatic vec_t mk(input logic rst, input logic iv, input logic [1:0] sel,
                              input logic [31:0] pc, input logic [31:0] a, input logic [31:0] mdr,
                              input logic ordy, input logic ev, input logic er, input logic cd,
                              input logic [31:0] ed, input logic [1:0] es, input logic ee);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sel = sel; v.pc = pc; v.a = a; v.mdr = mdr; v.ordy = ordy;
    v.e_valid = ev; v.e_rdy = er; v.chk_d = cd; v.e_data = ed; v.e_sel = es; v.e_err = ee;
    return v;
  endfunction

  initial begin
    drive(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);

    //           rst iv sel pc      a       mdr    ordy  ev er cd data     sel err
    tbl.push_back(mk(1, 0, 0, 0,      0,      0,     0,    0, 1, 1, 32'h0,   0, 0));
    tbl.push_back(mk(0, 1, 1, 0,      32'hA5, 0,     1,    1, 1, 1, 32'hA5,  1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h100, 32'h200, 32'h300, 1, 1, 1, 1, 32'h100, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h100, 32'h200, 32'h300, 1, 1, 1, 1, 32'h200, 1, 0));
    tbl.push_back(mk(0, 1, 2, 32'h100, 32'h200, 32'h300, 1, 1, 1, 1, 32'h300, 2, 0));
    tbl.push_back(mk(0, 1, 3, 32'h100, 32'h200, 32'h300, 1, 1, 1, 1, 32'h0,   3, 1));
    tbl.push_back(mk(0, 1, 0, 32'h7,  0,      0,     1,    1, 1, 1, 32'h7,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0,      0,     1,    0, 1, 0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 1, 1, 0,      32'h11, 0,     0,    1, 1, 1, 32'h11,  1, 0));
    tbl.push_back(mk(0, 1, 1, 0,      32'h22, 0,     0,    1, 0, 1, 32'h11,  1, 0));
    tbl.push_back(mk(0, 1, 1, 0,      32'h33, 0,     0,    1, 0, 1, 32'h11,  1, 0));
    tbl.push_back(mk(0, 0, 1, 0,      32'h33, 0,     1,    1, 1, 1, 32'h22,  1, 0));
    tbl.push_back(mk(0, 0, 1, 0,      32'h33, 0,     1,    0, 1, 0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 1, 1, 0,      32'h5,  0,     0,    1, 1, 1, 32'h5,   1, 0));
    tbl.push_back(mk(0, 0, 1, 0,      32'hFF, 0,     0,    1, 1, 1, 32'h5,   1, 0));
    tbl.push_back(mk(0, 0, 1, 0,      32'hFF, 0,     1,    0, 1, 0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h44, 0,      0,     0,    1, 1, 1, 32'h44,  0, 0));
    tbl.push_back(mk(0, 1, 2, 0,      0,      32'h55, 0,   1, 0, 1, 32'h44,  0, 0));
    tbl.push_back(mk(1, 1, 1, 0,      32'h66, 0,     1,    0, 1, 1, 32'h0,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0,      0,     1,    0, 1, 1, 32'h0,   0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].pc, tbl[i].a, tbl[i].mdr, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_rdy));
      if (tbl[i].chk_d) begin
        chk($sformatf("v%0d out_data", i), 64'(bus.out_data), 64'(tbl[i].e_data));
        chk($sformatf("v%0d out_sel", i), 64'(bus.out_sel), 64'(tbl[i].e_sel));
        chk($sformatf("v%0d out_err", i), 64'(bus.out_err), 64'(tbl[i].e_err));
      end
    end

    // Randomised traffic against a FIFO-of-beats reference; the block is empty here
    mq.delete();
    m_rdy = 1'b1;
    for (int c = 0; c < 400; c++) begin
      logic        rst, iv, ordy, acc, emi;
      logic [1:0]  sel;
      logic [31:0] pc, a, mdr;
      logic [31:0] src[3];
      beat_t       b;
      rst  = ($urandom_range(0, 59) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      sel  = 2'($urandom_range(0, 3));
      pc   = $urandom;
      a    = $urandom;
      mdr  = $urandom;
      drive(rst, iv, sel, pc, a, mdr, ordy);
      acc = iv && m_rdy;
      emi = (mq.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (rst) begin
        mq.delete();
      end else begin
        if (emi) void'(mq.pop_front());
        if (acc) begin
          src[0] = pc; src[1] = a; src[2] = mdr;
          b.sel  = sel;
          b.err  = (sel > 2'd2);
          b.data = b.err ? 32'h0 : src[sel];
          mq.push_back(b);
        end
      end
      m_rdy = (mq.size() < 2);
      chk($sformatf("r%0d out_valid", c), 64'(bus.out_valid), 64'(mq.size() > 0));
      chk($sformatf("r%0d in_ready", c), 64'(bus.in_ready), 64'(m_rdy));
      if (mq.size() > 0) begin
        chk($sformatf("r%0d out_data", c), 64'(bus.out_data), 64'(mq[0].data));
        chk($sformatf("r%0d out_sel", c), 64'(bus.out_sel), 64'(mq[0].sel));
        chk($sformatf("r%0d out_err", c), 64'(bus.out_err), 64'(mq[0].err));
      end else if (rst) begin
        chk($sformatf("r%0d rst out_data", c), 64'(bus.out_data), 64'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
